// File: rtl/reorder_buffer_pkg.sv
// Shared sizing constants for the reorder buffer and its operand resolver.
package reorder_buffer_pkg;

    localparam int unsigned ROB_SIZE  = 8;
    localparam int unsigned ID_WIDTH  = 4;
    localparam int unsigned REG_WIDTH = 5;
    localparam int unsigned VAL_WIDTH = 32;
    localparam int unsigned REG_SIZE  = 32;

    localparam int unsigned IDX_WIDTH = $clog2(ROB_SIZE);
    localparam int unsigned CNT_WIDTH = $clog2(ROB_SIZE + 1);

endpackage

// File: rtl/reorder_buffer_operand_resolve.sv
// Resolves one source operand label against the register file, a ROB entry and the CDB.
module rob_operand_resolve #(
    parameter int unsigned ID_WIDTH  = 4,
    parameter int unsigned VAL_WIDTH = 32
) (
    input  logic [ID_WIDTH-1:0]  lab,
    input  logic [VAL_WIDTH-1:0] rf_val,
    input  logic                 entry_ready,
    input  logic [VAL_WIDTH-1:0] entry_val,
    input  logic                 cdb_valid,
    input  logic [ID_WIDTH-1:0]  cdb_tag,
    input  logic [VAL_WIDTH-1:0] cdb_val,
    output logic [VAL_WIDTH-1:0] val,
    output logic [ID_WIDTH-1:0]  tag
);

    always_comb begin
        val = '0;
        tag = lab;
        if (lab == '0) begin
            val = rf_val;
            tag = '0;
        end else if (entry_ready) begin
            val = entry_val;
            tag = '0;
        end else if (cdb_valid && (cdb_tag == lab)) begin
            val = cdb_val;
            tag = '0;
        end
    end

endmodule

// File: rtl/reorder_buffer.sv
// In-order retirement queue: allocates tagged entries, renames rd, resolves operands,
// commits results in program order and flushes on a retiring mispredicted branch.
module reorder_buffer
    import reorder_buffer_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_in,
    input  logic                 rdy_in,
    input  logic                 dec_valid,
    input  logic [REG_WIDTH-1:0] dec_rd,
    output logic                 rob_full,
    output logic [ID_WIDTH-1:0]  alloc_tag,
    output logic [REG_WIDTH-1:0] rob2rf_rd,
    output logic [ID_WIDTH-1:0]  rob2rf_tag,
    input  logic [VAL_WIDTH-1:0] rf2rob_val1,
    input  logic [VAL_WIDTH-1:0] rf2rob_val2,
    input  logic [ID_WIDTH-1:0]  rf2rob_lab1,
    input  logic [ID_WIDTH-1:0]  rf2rob_lab2,
    output logic [VAL_WIDTH-1:0] op1_val,
    output logic [VAL_WIDTH-1:0] op2_val,
    output logic [ID_WIDTH-1:0]  op1_tag,
    output logic [ID_WIDTH-1:0]  op2_tag,
    input  logic                 cdb_valid,
    input  logic [ID_WIDTH-1:0]  cdb_tag,
    input  logic [VAL_WIDTH-1:0] cdb_val,
    input  logic                 cdb_mispredict,
    input  logic [VAL_WIDTH-1:0] cdb_target,
    output logic [REG_WIDTH-1:0] rob2rf_commit_rd,
    output logic [VAL_WIDTH-1:0] rob2rf_commit_res,
    output logic [ID_WIDTH-1:0]  rob2rf_commit_lab,
    output logic                 flush,
    output logic [VAL_WIDTH-1:0] flush_pc
);

    logic                 busy       [ROB_SIZE];
    logic                 ready      [ROB_SIZE];
    logic [REG_WIDTH-1:0] rd         [ROB_SIZE];
    logic [VAL_WIDTH-1:0] value      [ROB_SIZE];
    logic                 mispredict [ROB_SIZE];
    logic [VAL_WIDTH-1:0] target     [ROB_SIZE];

    logic [IDX_WIDTH-1:0] head, tail;
    logic [CNT_WIDTH-1:0] count;
    logic [IDX_WIDTH-1:0] head_next, tail_next;
    logic [IDX_WIDTH-1:0] wb_idx, lab1_idx, lab2_idx;
    logic                 alloc, commit;

    assign rob_full  = (count == CNT_WIDTH'(ROB_SIZE));
    assign alloc     = rdy_in && dec_valid && !rob_full && !flush;
    assign commit    = rdy_in && !flush && (count != '0) && busy[head] && ready[head];
    assign alloc_tag = ID_WIDTH'(tail) + ID_WIDTH'(1);

    assign head_next = (head == IDX_WIDTH'(ROB_SIZE - 1)) ? '0 : head + IDX_WIDTH'(1);
    assign tail_next = (tail == IDX_WIDTH'(ROB_SIZE - 1)) ? '0 : tail + IDX_WIDTH'(1);

    // Tags are entry index + 1; label 0 never reaches an entry lookup in the resolver.
    assign wb_idx   = IDX_WIDTH'(cdb_tag - ID_WIDTH'(1));
    assign lab1_idx = IDX_WIDTH'(rf2rob_lab1 - ID_WIDTH'(1));
    assign lab2_idx = IDX_WIDTH'(rf2rob_lab2 - ID_WIDTH'(1));

    assign rob2rf_rd  = alloc ? dec_rd : '0;
    assign rob2rf_tag = alloc ? alloc_tag : '0;

    assign rob2rf_commit_rd  = commit ? rd[head] : '0;
    assign rob2rf_commit_res = commit ? value[head] : '0;
    assign rob2rf_commit_lab = commit ? (ID_WIDTH'(head) + ID_WIDTH'(1)) : '0;

    always_ff @(posedge clk) begin
        if (rst_in) begin
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            flush    <= 1'b0;
            flush_pc <= '0;
            for (int unsigned i = 0; i < ROB_SIZE; i++) begin
                busy[i]       <= 1'b0;
                ready[i]      <= 1'b0;
                rd[i]         <= '0;
                value[i]      <= '0;
                mispredict[i] <= 1'b0;
                target[i]     <= '0;
            end
        end else if (rdy_in) begin
            if (flush) begin
                head  <= '0;
                tail  <= '0;
                count <= '0;
                flush <= 1'b0;
                for (int unsigned i = 0; i < ROB_SIZE; i++) begin
                    busy[i]       <= 1'b0;
                    ready[i]      <= 1'b0;
                    mispredict[i] <= 1'b0;
                end
            end else begin
                if (cdb_valid) begin
                    ready[wb_idx]      <= 1'b1;
                    value[wb_idx]      <= cdb_val;
                    mispredict[wb_idx] <= cdb_mispredict;
                    target[wb_idx]     <= cdb_target;
                end
                if (alloc) begin
                    busy[tail]       <= 1'b1;
                    ready[tail]      <= 1'b0;
                    rd[tail]         <= dec_rd;
                    mispredict[tail] <= 1'b0;
                    tail             <= tail_next;
                end
                if (commit) begin
                    busy[head] <= 1'b0;
                    head       <= head_next;
                    if (mispredict[head]) begin
                        flush    <= 1'b1;
                        flush_pc <= target[head];
                    end
                end
                case ({alloc, commit})
                    2'b10:   count <= count + CNT_WIDTH'(1);
                    2'b01:   count <= count - CNT_WIDTH'(1);
                    default: count <= count;
                endcase
            end
        end
    end

    rob_operand_resolve #(
        .ID_WIDTH  (ID_WIDTH),
        .VAL_WIDTH (VAL_WIDTH)
    ) u_resolve1 (
        .lab         (rf2rob_lab1),
        .rf_val      (rf2rob_val1),
        .entry_ready (ready[lab1_idx]),
        .entry_val   (value[lab1_idx]),
        .cdb_valid   (cdb_valid),
        .cdb_tag     (cdb_tag),
        .cdb_val     (cdb_val),
        .val         (op1_val),
        .tag         (op1_tag)
    );

    rob_operand_resolve #(
        .ID_WIDTH  (ID_WIDTH),
        .VAL_WIDTH (VAL_WIDTH)
    ) u_resolve2 (
        .lab         (rf2rob_lab2),
        .rf_val      (rf2rob_val2),
        .entry_ready (ready[lab2_idx]),
        .entry_val   (value[lab2_idx]),
        .cdb_valid   (cdb_valid),
        .cdb_tag     (cdb_tag),
        .cdb_val     (cdb_val),
        .val         (op2_val),
        .tag         (op2_tag)
    );

endmodule

// File: tb/tb_reorder_buffer.sv
// Scoreboard bench for reorder_buffer: allocations queue expected commits, a monitor checks retirement and flush.
module tb_reorder_buffer;
    import reorder_buffer_pkg::*;

    logic                 clk = 1'b0;
    logic                 rst_in, rdy_in, dec_valid;
    logic [REG_WIDTH-1:0] dec_rd;
    logic                 rob_full;
    logic [ID_WIDTH-1:0]  alloc_tag, rob2rf_tag;
    logic [REG_WIDTH-1:0] rob2rf_rd;
    logic [VAL_WIDTH-1:0] rf2rob_val1, rf2rob_val2;
    logic [ID_WIDTH-1:0]  rf2rob_lab1, rf2rob_lab2;
    logic [VAL_WIDTH-1:0] op1_val, op2_val;
    logic [ID_WIDTH-1:0]  op1_tag, op2_tag;
    logic                 cdb_valid, cdb_mispredict;
    logic [ID_WIDTH-1:0]  cdb_tag;
    logic [VAL_WIDTH-1:0] cdb_val, cdb_target;
    logic [REG_WIDTH-1:0] rob2rf_commit_rd;
    logic [VAL_WIDTH-1:0] rob2rf_commit_res;
    logic [ID_WIDTH-1:0]  rob2rf_commit_lab;
    logic                 flush;
    logic [VAL_WIDTH-1:0] flush_pc;

    typedef struct packed {
        logic [REG_WIDTH-1:0] rd;
        logic [ID_WIDTH-1:0]  lab;
    } exp_t;

    exp_t                 exp_q[$];
    logic [VAL_WIDTH-1:0] flush_q[$];
    logic [VAL_WIDTH-1:0] tag_val [0:ROB_SIZE];
    int unsigned          n_chk = 0;
    int unsigned          n_pass = 0;

    always #5 clk = ~clk;

    reorder_buffer dut (
        .clk               (clk),
        .rst_in            (rst_in),
        .rdy_in            (rdy_in),
        .dec_valid         (dec_valid),
        .dec_rd            (dec_rd),
        .rob_full          (rob_full),
        .alloc_tag         (alloc_tag),
        .rob2rf_rd         (rob2rf_rd),
        .rob2rf_tag        (rob2rf_tag),
        .rf2rob_val1       (rf2rob_val1),
        .rf2rob_val2       (rf2rob_val2),
        .rf2rob_lab1       (rf2rob_lab1),
        .rf2rob_lab2       (rf2rob_lab2),
        .op1_val           (op1_val),
        .op2_val           (op2_val),
        .op1_tag           (op1_tag),
        .op2_tag           (op2_tag),
        .cdb_valid         (cdb_valid),
        .cdb_tag           (cdb_tag),
        .cdb_val           (cdb_val),
        .cdb_mispredict    (cdb_mispredict),
        .cdb_target        (cdb_target),
        .rob2rf_commit_rd  (rob2rf_commit_rd),
        .rob2rf_commit_res (rob2rf_commit_res),
        .rob2rf_commit_lab (rob2rf_commit_lab),
        .flush             (flush),
        .flush_pc          (flush_pc)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic idle();
        rdy_in = 1'b1; dec_valid = 1'b0; dec_rd = '0;
        cdb_valid = 1'b0; cdb_tag = '0; cdb_val = '0; cdb_mispredict = 1'b0; cdb_target = '0;
        rf2rob_lab1 = '0; rf2rob_lab2 = '0; rf2rob_val1 = '0; rf2rob_val2 = '0;
    endtask

    task automatic alloc(input logic [REG_WIDTH-1:0] r, input logic [ID_WIDTH-1:0] t);
        dec_valid = 1'b1;
        dec_rd    = r;
        exp_q.push_back('{rd: r, lab: t});
    endtask

    task automatic cdb(input logic [ID_WIDTH-1:0] t, input logic [VAL_WIDTH-1:0] v,
                       input logic m, input logic [VAL_WIDTH-1:0] tgt);
        cdb_valid = 1'b1; cdb_tag = t; cdb_val = v; cdb_mispredict = m; cdb_target = tgt;
        tag_val[t] = v;
        if (m) flush_q.push_back(tgt);
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic settle();
        #2;
    endtask

    // Monitor: samples retirement/flush outputs mid-cycle, well clear of the posedge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #3;
            if (!rst_in && rob2rf_commit_lab != '0) begin
                if (exp_q.size() == 0) begin
                    n_chk++;
                    $display("FAIL unexpected_commit: got lab %0d, expected no commit", rob2rf_commit_lab);
                end else begin
                    e = exp_q.pop_front();
                    chk("commit_lab", 32'(rob2rf_commit_lab), 32'(e.lab));
                    chk("commit_rd", 32'(rob2rf_commit_rd), 32'(e.rd));
                    chk("commit_res", rob2rf_commit_res, tag_val[e.lab]);
                end
            end
            if (!rst_in && flush === 1'b1) begin
                if (flush_q.size() == 0) begin
                    n_chk++;
                    $display("FAIL unexpected_flush: got flush=1, expected 0");
                end else begin
                    chk("flush_pc", flush_pc, flush_q.pop_front());
                end
            end
        end
    end

    initial begin
        idle();
        rst_in = 1'b1;
        tick(); tick();
        rst_in = 1'b0;
        settle();
        chk("reset_full", 32'(rob_full), 0);
        chk("reset_alloc_tag", 32'(alloc_tag), 1);
        chk("reset_flush", 32'(flush), 0);
        chk("reset_flush_pc", flush_pc, 0);
        chk("reset_commit_rd", 32'(rob2rf_commit_rd), 0);

        tick(); idle(); alloc(5, 1); settle();
        chk("rename_rd", 32'(rob2rf_rd), 5);
        chk("rename_tag", 32'(rob2rf_tag), 1);
        tick(); idle(); alloc(6, 2); settle();
        chk("alloc_tag_after_one", 32'(alloc_tag), 2);
        tick(); idle(); alloc(7, 3);
        tick(); idle(); cdb(2, 32'h22, 1'b0, '0); settle();
        chk("head_not_ready", 32'(rob2rf_commit_rd), 0);
        tick(); idle(); cdb(1, 32'h11, 1'b0, '0);
        tick(); idle(); rf2rob_lab2 = 2; rf2rob_val1 = 32'h1234; settle();
        chk("op2_entry_val", op2_val, 32'h22);
        chk("op2_entry_tag", 32'(op2_tag), 0);
        chk("op1_rf_val", op1_val, 32'h1234);
        chk("op1_rf_tag", 32'(op1_tag), 0);
        tick(); idle();
        tick(); idle(); rf2rob_lab1 = 3; settle();
        chk("tag3_waits", 32'(rob2rf_commit_rd), 0);
        chk("op1_pending_tag", 32'(op1_tag), 3);
        chk("op1_pending_val", op1_val, 0);
        tick(); idle(); rf2rob_lab1 = 3; cdb(3, 32'h2A, 1'b0, '0); settle();
        chk("op1_cdb_val", op1_val, 32'h2A);
        chk("op1_cdb_tag", 32'(op1_tag), 0);
        tick(); idle();

        // head=tail=index 3 now, so the fill hands out tags 4..8 then wraps to 1..3
        for (int i = 0; i < 8; i++) begin
            tick(); idle(); alloc(REG_WIDTH'(i + 1), ID_WIDTH'(((3 + i) % 8) + 1)); settle();
            chk("fill_tag", 32'(rob2rf_tag), 32'(((3 + i) % 8) + 1));
        end
        tick(); idle(); dec_valid = 1'b1; dec_rd = 9; settle();
        chk("full_set", 32'(rob_full), 1);
        chk("full_ignore_rd", 32'(rob2rf_rd), 0);
        chk("full_ignore_tag", 32'(rob2rf_tag), 0);
        tick(); idle(); dec_valid = 1'b1; dec_rd = 9; cdb(4, 32'h44, 1'b0, '0); settle();
        chk("full_hold", 32'(rob_full), 1);
        tick(); idle(); dec_valid = 1'b1; dec_rd = 9; settle();
        chk("full_during_commit", 32'(rob_full), 1);
        chk("no_alloc_during_commit", 32'(rob2rf_rd), 0);
        tick(); idle(); settle();
        chk("full_dropped", 32'(rob_full), 0);
        alloc(9, 4); #1;
        chk("refill_tag", 32'(rob2rf_tag), 4);
        tick(); idle(); cdb(5, 32'h55, 1'b1, 32'h1000);
        tick(); idle(); settle();
        chk("flush_before", 32'(flush), 0);
        tick(); idle(); dec_valid = 1'b1; dec_rd = 3; settle();
        chk("flush_high", 32'(flush), 1);
        chk("flush_pc_val", flush_pc, 32'h1000);
        chk("flush_no_alloc", 32'(rob2rf_rd), 0);
        chk("flush_no_commit", 32'(rob2rf_commit_rd), 0);
        exp_q.delete();
        tick(); idle(); settle();
        chk("flush_one_cycle", 32'(flush), 0);
        chk("post_flush_tag", 32'(alloc_tag), 1);
        chk("post_flush_full", 32'(rob_full), 0);

        alloc(4, 1);
        tick(); idle(); cdb(1, 32'h99, 1'b0, '0);
        for (int i = 0; i < 3; i++) begin
            tick(); idle();
            rdy_in = 1'b0; dec_valid = 1'b1; dec_rd = 10;
            cdb_valid = 1'b1; cdb_tag = 1; cdb_val = 32'h77;
            settle();
            chk("freeze_commit_rd", 32'(rob2rf_commit_rd), 0);
            chk("freeze_rename_rd", 32'(rob2rf_rd), 0);
            chk("freeze_alloc_tag", 32'(alloc_tag), 2);
        end
        tick(); idle(); settle();
        chk("unfreeze_commit_rd", 32'(rob2rf_commit_rd), 4);
        tick(); idle(); settle();
        chk("unfreeze_alloc_tag", 32'(alloc_tag), 2);

        alloc(11, 2);
        tick(); idle(); alloc(12, 3);
        tick(); idle();
        rst_in = 1'b1; dec_valid = 1'b1; dec_rd = 14;
        cdb_valid = 1'b1; cdb_tag = 2; cdb_val = 32'hBB;
        exp_q.delete();
        tick(); idle(); rst_in = 1'b0; settle();
        chk("midreset_tag", 32'(alloc_tag), 1);
        chk("midreset_full", 32'(rob_full), 0);
        chk("midreset_commit", 32'(rob2rf_commit_rd), 0);
        tick(); idle(); alloc(13, 1); settle();
        chk("midreset_rename_rd", 32'(rob2rf_rd), 13);
        chk("midreset_rename_tag", 32'(rob2rf_tag), 1);
        tick(); idle(); cdb(1, 32'hAB, 1'b0, '0);
        tick(); idle(); settle();
        chk("final_commit_rd", 32'(rob2rf_commit_rd), 13);
        tick(); idle();
        tick();
        chk("commit_queue_drained", 32'(exp_q.size()), 0);
        chk("flush_queue_drained", 32'(flush_q.size()), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
